// File: rtl/sram16_ctrl.sv
// Bus-slave controller for an asynchronous 16-bit byte-lane SRAM.
// Each bus transfer becomes one timed SRAM cycle: address setup, strobe, done, recovery.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | CE_n high; waiting for cyc & stb
// ACCESS  | CE_n low; first cycle is address setup, then OE_n/WE_n low
// DONE    | strobes released, CE_n low, write data still driven; ack
// RECOVER | all strobes high for TURN cycles before the next access
module sram16_ctrl #(
   parameter int ADR_W   = 19,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2,
   parameter int TURN    = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [63:0]       s_adr_i,
   input  logic              s_cyc_i,
   input  logic              s_stb_i,
   input  logic              s_we_i,
   input  logic              s_siz_i,
   input  logic [15:0]       s_dat_i,
   output logic              s_ack_o,
   output logic [15:0]       s_dat_o,
   output logic [ADR_W-1:0]  sram_adr_o,
   output logic [15:0]       sram_dat_o,
   output logic              sram_dat_oe_o,
   input  logic [15:0]       sram_dat_i,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o,
   output logic              sram_ub_n_o,
   output logic              sram_lb_n_o
);

   localparam logic [3:0] RD_CNT   = 4'(RD_WAIT);
   localparam logic [3:0] WR_CNT   = 4'(WR_WAIT);
   localparam logic [3:0] TURN_CNT = 4'(TURN);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_DONE    = 2'd2,
      ST_RECOVER = 2'd3
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        setup_q;
   logic        we_q;
   logic        siz_q;
   logic        byte_hi_q;
   logic        abort_q;
   logic        ack_q;
   logic [15:0] hold_q;
   logic [15:0] rd_steer;

   // Address bits above the SRAM range alias onto the same locations.
   logic        unused_adr;
   assign unused_adr = ^s_adr_i[63:ADR_W+1];

   always_comb begin
      rd_steer = sram_dat_i;
      if (!siz_q) begin
         rd_steer = byte_hi_q ? {8'h00, sram_dat_i[15:8]} : {8'h00, sram_dat_i[7:0]};
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state         <= ST_IDLE;
         cnt           <= 4'd0;
         setup_q       <= 1'b0;
         we_q          <= 1'b0;
         siz_q         <= 1'b0;
         byte_hi_q     <= 1'b0;
         abort_q       <= 1'b0;
         ack_q         <= 1'b0;
         hold_q        <= 16'h0000;
         sram_adr_o    <= '0;
         sram_dat_o    <= 16'h0000;
         sram_dat_oe_o <= 1'b0;
         sram_ce_n_o   <= 1'b1;
         sram_oe_n_o   <= 1'b1;
         sram_we_n_o   <= 1'b1;
         sram_ub_n_o   <= 1'b1;
         sram_lb_n_o   <= 1'b1;
      end else begin
         ack_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (s_cyc_i && s_stb_i) begin
                  state       <= ST_ACCESS;
                  setup_q     <= 1'b1;
                  we_q        <= s_we_i;
                  siz_q       <= s_siz_i;
                  byte_hi_q   <= s_adr_i[0];
                  abort_q     <= 1'b0;
                  cnt         <= s_we_i ? WR_CNT : RD_CNT;
                  sram_adr_o  <= s_adr_i[ADR_W:1];
                  // Byte writes replicate the byte; the lane enables pick the half.
                  sram_dat_o  <= s_siz_i ? s_dat_i : {s_dat_i[7:0], s_dat_i[7:0]};
                  sram_ce_n_o <= 1'b0;
                  sram_ub_n_o <= ~(s_siz_i | s_adr_i[0]);
                  sram_lb_n_o <= ~(s_siz_i | ~s_adr_i[0]);
               end
            end

            ST_ACCESS: begin
               if (!s_cyc_i) begin
                  abort_q <= 1'b1;
               end
               if (setup_q) begin
                  setup_q       <= 1'b0;
                  sram_oe_n_o   <= we_q;
                  sram_we_n_o   <= ~we_q;
                  sram_dat_oe_o <= we_q;
               end else if (cnt == 4'd1) begin
                  state       <= ST_DONE;
                  sram_oe_n_o <= 1'b1;
                  sram_we_n_o <= 1'b1;
                  ack_q       <= s_cyc_i & ~abort_q;
                  if (!we_q) begin
                     hold_q <= rd_steer;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            ST_DONE: begin
               sram_ce_n_o   <= 1'b1;
               sram_ub_n_o   <= 1'b1;
               sram_lb_n_o   <= 1'b1;
               sram_dat_oe_o <= 1'b0;
               if (TURN_CNT == 4'd0) begin
                  state <= ST_IDLE;
               end else begin
                  state <= ST_RECOVER;
                  cnt   <= TURN_CNT;
               end
            end

            ST_RECOVER: begin
               if (cnt == 4'd1) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign s_ack_o = ack_q;
   assign s_dat_o = (state == ST_DONE && !we_q) ? hold_q : 16'h0000;

endmodule

// File: tb/tb_sram16_ctrl.sv
// Directed bench for sram16_ctrl with a behavioural byte-lane SRAM model.
module tb_sram16_ctrl;

   localparam int ADR_W   = 19;
   localparam int RD_WAIT = 2;
   localparam int WR_WAIT = 2;
   localparam int TURN    = 1;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic [63:0]       s_adr_i;
   logic              s_cyc_i;
   logic              s_stb_i;
   logic              s_we_i;
   logic              s_siz_i;
   logic [15:0]       s_dat_i;
   logic              s_ack_o;
   logic [15:0]       s_dat_o;
   logic [ADR_W-1:0]  sram_adr_o;
   logic [15:0]       sram_dat_o;
   logic              sram_dat_oe_o;
   logic [15:0]       sram_dat_i;
   logic              sram_ce_n_o;
   logic              sram_oe_n_o;
   logic              sram_we_n_o;
   logic              sram_ub_n_o;
   logic              sram_lb_n_o;

   int n_tests = 0;
   int n_fail  = 0;

   sram16_ctrl #(.ADR_W(ADR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN(TURN)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .s_adr_i(s_adr_i), .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
      .s_siz_i(s_siz_i), .s_dat_i(s_dat_i), .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
      .sram_adr_o(sram_adr_o), .sram_dat_o(sram_dat_o), .sram_dat_oe_o(sram_dat_oe_o),
      .sram_dat_i(sram_dat_i), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
      .sram_we_n_o(sram_we_n_o), .sram_ub_n_o(sram_ub_n_o), .sram_lb_n_o(sram_lb_n_o)
   );

   always #5 clk_i = ~clk_i;

   // SRAM model: 4K halfwords, lane-masked writes on rising edge while WE_n low
   logic [15:0] mem [0:4095];
   assign sram_dat_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_adr_o[11:0]] : 16'hDEAD;

   always @(posedge clk_i) begin
      if (!sram_ce_n_o && !sram_we_n_o) begin
         if (!sram_ub_n_o) mem[sram_adr_o[11:0]][15:8] <= sram_dat_o[15:8];
         if (!sram_lb_n_o) mem[sram_adr_o[11:0]][7:0]  <= sram_dat_o[7:0];
      end
   end

   // Bus/pad monitor sampled on the falling edge
   int          we_lo   = 0;
   int          ack_cnt = 0;
   int          dbl_ack = 0;
   int          oe_viol = 0;
   logic        prev_ack = 1'b0;
   logic [18:0] cap_adr;
   logic        cap_ub, cap_lb;
   logic [15:0] cap_wdat;

   always @(negedge clk_i) begin
      if (!sram_ce_n_o) begin
         cap_adr = sram_adr_o;
         cap_ub  = sram_ub_n_o;
         cap_lb  = sram_lb_n_o;
      end
      if (!sram_we_n_o) begin
         we_lo++;
         cap_wdat = sram_dat_o;
         if (!sram_dat_oe_o) oe_viol++;
      end
      if (s_ack_o) ack_cnt++;
      if (s_ack_o && prev_ack) dbl_ack++;
      prev_ack = s_ack_o;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bus transfer; lat counts rising edges from the accepting edge until ack is seen.
   task automatic xfer(input logic we, input logic siz, input logic [63:0] adr,
                       input logic [15:0] dat, output logic [15:0] rdat, output int lat);
      we_lo   = 0;
      ack_cnt = 0;
      rdat    = 16'h0;
      @(negedge clk_i);
      s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_siz_i = siz;
      s_adr_i = adr;  s_dat_i = dat;
      @(posedge clk_i);
      lat = 1;
      #1 s_stb_i = 1'b0;
      while (lat < 40) begin
         @(negedge clk_i);
         if (s_ack_o) begin
            rdat = s_dat_o;
            break;
         end
         @(posedge clk_i);
         lat++;
      end
      s_cyc_i = 1'b0;
      repeat (6) @(posedge clk_i);
   endtask

   logic [15:0] rd;
   int          lat;
   int          t, last_t, n_ack, ce_hi, min_gap, min_ce;
   logic [15:0] rd_seq [4];

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
      reset_i = 1'b1;
      s_adr_i = 64'h0; s_cyc_i = 1'b0; s_stb_i = 1'b0;
      s_we_i  = 1'b0;  s_siz_i = 1'b0; s_dat_i = 16'h0;

      #3;
      check("rst_ack",   32'(s_ack_o), 32'h0);
      check("rst_dat",   32'(s_dat_o), 32'h0);
      check("rst_ce_n",  32'(sram_ce_n_o), 32'h1);
      check("rst_we_n",  32'(sram_we_n_o), 32'h1);
      check("rst_dat_oe",32'(sram_dat_oe_o), 32'h0);
      check("rst_adr",   32'(sram_adr_o), 32'h0);
      #20 reset_i = 1'b0;
      repeat (2) @(posedge clk_i);

      // T2: halfword read
      mem[12'h91A] = 16'hBEEF;
      xfer(1'b0, 1'b1, 64'h1234, 16'h0, rd, lat);
      check("t2_adr", 32'(cap_adr), 32'h091A);
      check("t2_ub",  32'(cap_ub), 32'h0);
      check("t2_lb",  32'(cap_lb), 32'h0);
      check("t2_lat", 32'(lat), 32'd4);
      check("t2_dat", 32'(rd), 32'hBEEF);
      check("t2_acks",32'(ack_cnt), 32'd1);
      check("t2_dat_idle", 32'(s_dat_o), 32'h0);

      // T3: upper-lane byte write
      mem[2] = 16'h1111;
      xfer(1'b1, 1'b0, 64'h0005, 16'h00A5, rd, lat);
      check("t3_ub",   32'(cap_ub), 32'h0);
      check("t3_lb",   32'(cap_lb), 32'h1);
      check("t3_whi",  32'(cap_wdat[15:8]), 32'hA5);
      check("t3_welo", 32'(we_lo), 32'd2);
      check("t3_acks", 32'(ack_cnt), 32'd1);
      check("t3_lat",  32'(lat), 32'd4);
      check("t3_rdat", 32'(rd), 32'h0);
      check("t3_mem",  32'(mem[2]), 32'hA511);

      // T4: byte reads from both lanes
      mem[3] = 16'h5A3C;
      xfer(1'b0, 1'b0, 64'h0007, 16'h0, rd, lat);
      check("t4_hi", 32'(rd), 32'h005A);
      xfer(1'b0, 1'b0, 64'h0006, 16'h0, rd, lat);
      check("t4_lo", 32'(rd), 32'h003C);
      // High address bits alias onto the same word
      xfer(1'b0, 1'b0, 64'hFFF0_0000_0010_0007, 16'h0, rd, lat);
      check("t4_alias", 32'(rd), 32'h005A);

      // T1: reset asserted while WE_n is low
      @(negedge clk_i);
      s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_siz_i = 1'b1;
      s_adr_i = 64'h0080; s_dat_i = 16'h1357;
      @(posedge clk_i);
      #1 s_stb_i = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      check("t1_we_active", 32'(sram_we_n_o), 32'h0);
      reset_i = 1'b1;
      #1;
      check("t1_we_n",   32'(sram_we_n_o), 32'h1);
      check("t1_ce_n",   32'(sram_ce_n_o), 32'h1);
      check("t1_dat_oe", 32'(sram_dat_oe_o), 32'h0);
      #3 reset_i = 1'b0;
      ack_cnt = 0;
      repeat (10) @(posedge clk_i);
      s_cyc_i = 1'b0;
      check("t1_no_ack", 32'(ack_cnt), 32'd0);

      // T5: four halfword reads with stb held high
      mem[12'h100] = 16'h1001; mem[12'h101] = 16'h2002;
      mem[12'h102] = 16'h3003; mem[12'h103] = 16'h4004;
      @(negedge clk_i);
      s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_siz_i = 1'b1; s_adr_i = 64'h0200;
      t = 0; last_t = 0; n_ack = 0; ce_hi = 0; min_gap = 1000; min_ce = 1000;
      while (n_ack < 4 && t < 80) begin
         @(negedge clk_i);
         t++;
         if (sram_ce_n_o) ce_hi++;
         if (s_ack_o) begin
            rd_seq[n_ack] = s_dat_o;
            if (n_ack > 0) begin
               if (t - last_t < min_gap) min_gap = t - last_t;
               if (ce_hi < min_ce) min_ce = ce_hi;
            end
            last_t = t;
            ce_hi  = 0;
            n_ack++;
            s_adr_i = s_adr_i + 64'd2;
         end
      end
      s_stb_i = 1'b0; s_cyc_i = 1'b0;
      repeat (8) @(posedge clk_i);
      check("t5_acks", 32'(n_ack), 32'd4);
      check("t5_d0", 32'(rd_seq[0]), 32'h1001);
      check("t5_d1", 32'(rd_seq[1]), 32'h2002);
      check("t5_d2", 32'(rd_seq[2]), 32'h3003);
      check("t5_d3", 32'(rd_seq[3]), 32'h4004);
      check("t5_gap_ok", 32'(min_gap >= RD_WAIT + 2 + TURN), 32'h1);
      check("t5_ce_hi_ok", 32'(min_ce >= TURN), 32'h1);

      // T6: cyc dropped during a write's ACCESS phase
      mem[12'h180] = 16'h0000;
      we_lo = 0; ack_cnt = 0;
      @(negedge clk_i);
      s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1; s_siz_i = 1'b1;
      s_adr_i = 64'h0300; s_dat_i = 16'hC0DE;
      @(posedge clk_i);
      #1 s_stb_i = 1'b0;
      @(posedge clk_i);
      #1 s_cyc_i = 1'b0;
      repeat (12) @(posedge clk_i);
      #1;
      check("t6_no_ack", 32'(ack_cnt), 32'd0);
      check("t6_welo",   32'(we_lo), 32'd2);
      check("t6_mem",    32'(mem[12'h180]), 32'hC0DE);
      check("t6_ce_n",   32'(sram_ce_n_o), 32'h1);
      xfer(1'b0, 1'b1, 64'h0300, 16'h0, rd, lat);
      check("t6_rd_lat", 32'(lat), 32'd4);
      check("t6_rd_dat", 32'(rd), 32'hC0DE);

      check("dbl_ack", 32'(dbl_ack), 32'd0);
      check("we_without_oe", 32'(oe_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
